forward_west_stage: RTL and testbench
=====================================

# forward_west_stage

West-side forwarding stage of the mesh router. Each accepted 16-bit packet is steered by its signed X offset: negative offsets go one hop further west, zero offset is delivered to the local port, and positive offsets are illegal here and are dropped with an error pulse. The stage sits between the router input arbitration and the west/local output ports. It provides one registered holding slot with a valid/ready handshake on every port.

## Interface
- No parameters. Packet width is fixed at 16 bits; field positions come from the shared package.
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- packet_in  input  16  incoming packet; [15:12] dx (signed 4-bit), [11:0] opaque payload
- valid_in  input  1  packet_in is valid
- ready_in  output  1  stage can accept a packet this cycle
- packet_west  output  16  west-bound packet, with dx already updated
- valid_west  output  1  packet_west is valid
- ready_west  input  1  west neighbour accepts this cycle
- packet_local  output  16  local-bound packet, unmodified
- valid_local  output  1  packet_local is valid
- ready_local  input  1  local port accepts this cycle
- drop_err  output  1  one-cycle pulse when an illegal (dx>0) packet is consumed

## Operation
- Accept condition: valid_in && ready_in.
- Classification on accept, with dx = signed packet_in[15:12]:
  - dx<0: destination WEST. The stored packet has dx replaced by dx+1 (4-bit two's complement); payload [11:0] is unchanged. Example: dx=-8 becomes -7, dx=-1 becomes 0.
  - dx==0: destination LOCAL. The packet is stored unmodified.
  - dx>0: the packet is consumed but not stored. drop_err=1 in the following cycle, and the holding slot is unaffected.
- Holding slot state: hold_valid, hold_dest (WEST/LOCAL), hold_pkt.
- Output drive:
  - valid_west = hold_valid && hold_dest==WEST.
  - valid_local = hold_valid && hold_dest==LOCAL.
  - packet_west and packet_local both drive hold_pkt; the valid signals qualify them.
- Slot drain: the slot empties when the selected destination's ready is high.
- Backpressure: ready_in = !hold_valid || (the selected destination's ready is high). This allows full throughput when the destination is ready.
- Simultaneous drain and accept in the same cycle: the slot is reloaded with the new packet. If the new packet is dx>0, the slot empties and drop_err pulses.
- The ready of the non-selected port is ignored.
- Once valid_west/valid_local is asserted, its packet and valid stay stable until the handshake completes.

## Timing
- Reset values: hold_valid=0, hold_pkt=16'h0000, hold_dest=LOCAL, drop_err=0. This gives valid_west=valid_local=0, packet_west=packet_local=16'h0000, and ready_in=1 in the first cycle after reset.
- Reset takes priority over all other activity. A packet held when reset asserts is discarded, and an input presented during reset is not accepted.
- Latency: one cycle from accept to output valid.
- Throughput: one packet per cycle with no bubbles while the destination stays ready.
- drop_err is registered: it is high for exactly the one cycle after a dx>0 accept and low otherwise.
- ready_in is combinational from hold_valid, hold_dest, ready_west and ready_local. There is no combinational path from valid_in to any output.

## Structure
- Shared package router_pkg contains:
  - DX_MSB=15, DX_LSB=12
  - typedef dest_t {DEST_LOCAL, DEST_WEST}
  - PKT_W=16
  - function next_dx_west(dx) returning dx+1
- One sub-module is natural: route_classify_west. It is combinational: packet in; dest, updated packet and illegal flag out.
- The holding register and handshake logic live in the top-level stage.

## Test plan
- Reset, then packet_in=16'hE000, valid_in=1 for one cycle → next cycle valid_west=1, packet_west=16'hF000, valid_local=0.
- packet_in=16'h0000, valid_in=1 → next cycle valid_local=1, packet_local=16'h0000, valid_west=0.
- packet_in=16'h2345, valid_in=1 → next cycle drop_err=1 for exactly one cycle; valid_west=valid_local=0.
- Hold 16'hE0AB (dx=-2) with ready_west=0 for 3 cycles → valid_west stays 1, packet_west stays 16'hF0AB, ready_in=0. Drop ready_local at the same time to confirm it has no effect. Then set ready_west=1 → drains.
- Back-to-back 16'h8001, 16'h0002, 16'hF003 with both readies high → outputs on consecutive cycles: west 16'h9001, local 16'h0002, west 16'h0003 routed west (dx 0 after update). ready_in stays 1 throughout.
- Assert rst while a west packet is held and ready_west=0 → next cycle all valids=0, packets=16'h0000, ready_in=1.

Source files
------------

// File: rtl/router_pkg.sv
// Shared mesh-router definitions: packet field positions, destination
// encoding and the west-hop dx update helper.
package router_pkg;

    localparam int PKT_W  = 16;
    localparam int DX_MSB = 15;
    localparam int DX_LSB = 12;

    typedef enum logic {
        DEST_LOCAL = 1'b0,
        DEST_WEST  = 1'b1
    } dest_t;

    // One hop west moves the packet one step closer to its target column.
    function automatic logic [DX_MSB-DX_LSB:0] next_dx_west(input logic [DX_MSB-DX_LSB:0] dx);
        return dx + 1'b1;
    endfunction

endpackage

// File: rtl/route_classify_west.sv
// Combinational steering decision for a packet entering the west stage:
// picks the destination, rewrites dx for west hops, flags dx>0 as illegal.
module route_classify_west
    import router_pkg::*;
(
    input  logic [PKT_W-1:0] packet_i,
    output dest_t            dest_o,
    output logic [PKT_W-1:0] packet_o,
    output logic             illegal_o
);

    logic [DX_MSB-DX_LSB:0] dx;
    logic                   dxNegative;
    logic                   dxZero;

    assign dx         = packet_i[DX_MSB:DX_LSB];
    assign dxNegative = dx[DX_MSB-DX_LSB];
    assign dxZero     = (dx == '0);

    always_comb begin
        dest_o    = DEST_LOCAL;
        packet_o  = packet_i;
        illegal_o = 1'b0;
        if (dxNegative) begin
            dest_o   = DEST_WEST;
            packet_o = {next_dx_west(dx), packet_i[DX_LSB-1:0]};
        end else if (!dxZero) begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/forward_west_stage.sv
// West-side forwarding stage: one registered holding slot with valid/ready
// handshakes toward the west neighbour and the local port.
module forward_west_stage
    import router_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] packet_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [PKT_W-1:0] packet_west,
    output logic             valid_west,
    input  logic             ready_west,
    output logic [PKT_W-1:0] packet_local,
    output logic             valid_local,
    input  logic             ready_local,
    output logic             drop_err
);

    logic             hold_valid_q, hold_valid_d;
    dest_t            hold_dest_q,  hold_dest_d;
    logic [PKT_W-1:0] hold_pkt_q,   hold_pkt_d;
    logic             drop_err_q,   drop_err_d;

    dest_t            cls_dest;
    logic [PKT_W-1:0] cls_pkt;
    logic             cls_illegal;

    logic             sel_ready;
    logic             drain;
    logic             accept;

    route_classify_west u_classify (
        .packet_i  (packet_in),
        .dest_o    (cls_dest),
        .packet_o  (cls_pkt),
        .illegal_o (cls_illegal)
    );

    // Only the ready of the port the held packet is headed for matters.
    assign sel_ready = (hold_dest_q == DEST_WEST) ? ready_west : ready_local;
    assign drain     = hold_valid_q && sel_ready;
    assign ready_in  = !hold_valid_q || sel_ready;
    assign accept    = valid_in && ready_in;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_dest_d  = hold_dest_q;
        hold_pkt_d   = hold_pkt_q;
        drop_err_d   = 1'b0;
        if (drain) begin
            hold_valid_d = 1'b0;
        end
        if (accept) begin
            if (cls_illegal) begin
                drop_err_d = 1'b1;
            end else begin
                hold_valid_d = 1'b1;
                hold_dest_d  = cls_dest;
                hold_pkt_d   = cls_pkt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_dest_q  <= DEST_LOCAL;
            hold_pkt_q   <= '0;
            drop_err_q   <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_dest_q  <= hold_dest_d;
            hold_pkt_q   <= hold_pkt_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign valid_west   = hold_valid_q && (hold_dest_q == DEST_WEST);
    assign valid_local  = hold_valid_q && (hold_dest_q == DEST_LOCAL);
    assign packet_west  = hold_pkt_q;
    assign packet_local = hold_pkt_q;
    assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_forward_west_stage.sv
// Bench for forward_west_stage: directed vector table, reset-while-holding
// sequence, then randomized traffic against a behavioural slot model.
module tb_forward_west_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] packet_in;
    logic        valid_in;
    logic        ready_in;
    logic [15:0] packet_west;
    logic        valid_west;
    logic        ready_west;
    logic [15:0] packet_local;
    logic        valid_local;
    logic        ready_local;
    logic        drop_err;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] pkt;
        logic        vin;
        logic        rw;
        logic        rl;
        logic        expRdy;
        logic        expVw;
        logic        expVl;
        logic [15:0] expPkt;
        logic        expDrop;
    } vec_t;

    vec_t vecs[13];

    logic        mValid;
    logic        mWest;
    logic [15:0] mPkt;
    logic        mDrop;

    forward_west_stage dut (
        .clk          (clk),
        .rst          (rst),
        .packet_in    (packet_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .packet_west  (packet_west),
        .valid_west   (valid_west),
        .ready_west   (ready_west),
        .packet_local (packet_local),
        .valid_local  (valid_local),
        .ready_local  (ready_local),
        .drop_err     (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] p, input logic v, input logic rw,
                                 input logic rl, input logic r);
        packet_in   = p;
        valid_in    = v;
        ready_west  = rw;
        ready_local = rl;
        rst         = r;
    endtask

    task automatic checkOutput(input string tag, input logic vw, input logic vl,
                               input logic [15:0] pkt, input logic drop);
        check({tag, ".valid_west"},   16'(valid_west),  16'(vw));
        check({tag, ".valid_local"},  16'(valid_local), 16'(vl));
        check({tag, ".packet_west"},  packet_west,      pkt);
        check({tag, ".packet_local"}, packet_local,     pkt);
        check({tag, ".drop_err"},     16'(drop_err),    16'(drop));
    endtask

    // Slot behaviour written directly from the routing rules with signed dx arithmetic.
    task automatic modelStep(input logic [15:0] p, input logic v, input logic rw,
                             input logic rl, input logic r);
        logic        rdy;
        int          dx;
        logic [3:0]  nd;
        if (r) begin
            mValid = 1'b0;
            mWest  = 1'b0;
            mPkt   = 16'h0000;
            mDrop  = 1'b0;
            return;
        end
        rdy   = !mValid || (mWest ? rw : rl);
        mDrop = 1'b0;
        if (mValid && (mWest ? rw : rl)) mValid = 1'b0;
        if (v && rdy) begin
            dx = int'(p[15:12]);
            if (dx > 7) dx = dx - 16;
            if (dx > 0) begin
                mDrop = 1'b1;
            end else if (dx == 0) begin
                mValid = 1'b1;
                mWest  = 1'b0;
                mPkt   = p;
            end else begin
                nd     = 4'(dx + 1);
                mValid = 1'b1;
                mWest  = 1'b1;
                mPkt   = {nd, p[11:0]};
            end
        end
    endtask

    initial begin
        vecs[0]  = '{16'hE000, 1, 1, 1, 1, 1, 0, 16'hF000, 0};
        vecs[1]  = '{16'h0000, 1, 1, 1, 1, 0, 1, 16'h0000, 0};
        vecs[2]  = '{16'h2345, 1, 1, 1, 1, 0, 0, 16'h0000, 1};
        vecs[3]  = '{16'h0000, 0, 1, 1, 1, 0, 0, 16'h0000, 0};
        vecs[4]  = '{16'hE0AB, 1, 1, 1, 1, 1, 0, 16'hF0AB, 0};
        vecs[5]  = '{16'h0000, 0, 0, 0, 0, 1, 0, 16'hF0AB, 0};
        vecs[6]  = '{16'h1234, 1, 0, 0, 0, 1, 0, 16'hF0AB, 0};
        vecs[7]  = '{16'h0000, 0, 0, 1, 0, 1, 0, 16'hF0AB, 0};
        vecs[8]  = '{16'h0000, 0, 1, 0, 1, 0, 0, 16'hF0AB, 0};
        vecs[9]  = '{16'h8001, 1, 1, 1, 1, 1, 0, 16'h9001, 0};
        vecs[10] = '{16'h0002, 1, 1, 1, 1, 0, 1, 16'h0002, 0};
        vecs[11] = '{16'hF003, 1, 1, 1, 1, 1, 0, 16'h0003, 0};
        vecs[12] = '{16'h0000, 0, 1, 1, 1, 0, 0, 16'h0003, 0};

        applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, 16'h0000, 1'b0);
        check("reset.ready_in", 16'(ready_in), 16'd1);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].pkt, vecs[i].vin, vecs[i].rw, vecs[i].rl, 1'b0);
            #1;
            check($sformatf("vec%0d.ready_in", i), 16'(ready_in), 16'(vecs[i].expRdy));
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].expVw, vecs[i].expVl,
                        vecs[i].expPkt, vecs[i].expDrop);
        end

        // Reset arriving while a west packet is stuck behind backpressure.
        applyStimulus(16'hE0AB, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rsthold.load", 1'b1, 1'b0, 16'hF0AB, 1'b0);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        check("rsthold.ready_in_before", 16'(ready_in), 16'd0);
        @(negedge clk);
        checkOutput("rsthold.after", 1'b0, 1'b0, 16'h0000, 1'b0);
        check("rsthold.ready_in_after", 16'(ready_in), 16'd1);

        modelStep(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 2000; n++) begin
            logic [15:0] p;
            logic        v, rw, rl, r;
            p  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) p[15:12] = 4'h0;
            v  = ($urandom_range(0, 3) != 0);
            rw = ($urandom_range(0, 2) != 0);
            rl = ($urandom_range(0, 2) != 0);
            r  = ($urandom_range(0, 63) == 0);
            applyStimulus(p, v, rw, rl, r);
            #1;
            check("rand.ready_in", 16'(ready_in),
                  16'(!mValid || (mWest ? rw : rl)));
            modelStep(p, v, rw, rl, r);
            @(negedge clk);
            checkOutput("rand", mValid && mWest, mValid && !mWest, mPkt, mDrop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
